// File: rtl/data_c_pkg.sv
// Shared definitions for the data_c round-robin merge block.
//   state_e   : arbiter FSM states (free arbitration / locked to one packet)
//   calc_idw  : width of a channel index, never narrower than one bit
package data_c_pkg;

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    function automatic int calc_idw(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority picker (purely combinational).
//   req : per-channel request vector
//   ptr : last granted channel; the search starts at ptr+1 and wraps at NUM-1
//   gnt : index of the first requesting channel found
//   any : high when at least one channel requests
module rr_pick
    import data_c_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IDW = calc_idw(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt,
    output logic           any
);

    int idx_s;

    // Walk the channels in cyclic order after ptr and keep the first requester.
    always_comb begin
        gnt   = {IDW{1'b0}};
        any   = 1'b0;
        idx_s = 0;
        for (int i = 1; i <= NUM; i++) begin
            idx_s = (int'(ptr) + i) % NUM;
            if (!any && req[idx_s]) begin
                any = 1'b1;
                gnt = IDW'(idx_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/data_c_rr_merge.sv
// Round-robin merge of NUM valid/ready channels into one registered stream.
//   clock, rst       : single clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready : NUM input channels (channel k data at k*DSIZE)
//   m_valid/m_data/m_last/m_id/m_ready : merged output; m_id names the source channel
// With PKT_LOCK=1 a channel keeps the grant from its first beat until its s_last beat.
module data_c_rr_merge
    import data_c_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int NUM      = 4,
    parameter int PKT_LOCK = 1,
    parameter int IDW      = calc_idw(NUM)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NUM-1:0]       s_valid,
    input  logic [NUM*DSIZE-1:0] s_data,
    input  logic [NUM-1:0]       s_last,
    output logic [NUM-1:0]       s_ready,
    output logic                 m_valid,
    output logic [DSIZE-1:0]     m_data,
    output logic                 m_last,
    output logic [IDW-1:0]       m_id,
    input  logic                 m_ready
);

    state_e             state_r;
    state_e             nxt_state_s;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     pick_gnt_s;
    logic               pick_any_s;
    logic [IDW-1:0]     gnt_s;
    logic               gnt_en_s;
    logic               load_s;
    logic               xfer_s;
    logic [DSIZE-1:0]   gnt_data_s;
    logic               gnt_last_s;
    logic [NUM-1:0]     s_ready_s;

    rr_pick #(
        .NUM (NUM),
        .IDW (IDW)
    ) u_pick (
        .req (s_valid),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .any (pick_any_s)
    );

    // Grant selection, ready generation and transfer detection.
    always_comb begin
        load_s = !m_valid || m_ready;
        if (state_r == ST_LOCK) begin
            // Locked: the packet owner keeps the grant even if it idles a cycle.
            gnt_s    = ptr_r;
            gnt_en_s = 1'b1;
        end else begin
            gnt_s    = pick_gnt_s;
            gnt_en_s = pick_any_s;
        end
        s_ready_s = {NUM{1'b0}};
        if (gnt_en_s && load_s && !rst) begin
            s_ready_s[gnt_s] = 1'b1;
        end else begin
            s_ready_s = {NUM{1'b0}};
        end
        xfer_s     = gnt_en_s && load_s && !rst && s_valid[gnt_s];
        gnt_data_s = s_data[int'(gnt_s)*DSIZE +: DSIZE];
        gnt_last_s = s_last[gnt_s];
    end

    assign s_ready = s_ready_s;

    // Next arbiter state: lock on a non-final beat, unlock on the final one.
    always_comb begin
        case (state_r)
            ST_ARB: begin
                if (xfer_s && (PKT_LOCK != 0) && !gnt_last_s) begin
                    nxt_state_s = ST_LOCK;
                end else begin
                    nxt_state_s = ST_ARB;
                end
            end
            ST_LOCK: begin
                if (xfer_s && gnt_last_s) begin
                    nxt_state_s = ST_ARB;
                end else begin
                    nxt_state_s = ST_LOCK;
                end
            end
            default: nxt_state_s = ST_ARB;
        endcase
    end

    // FSM, round-robin pointer and the single output register stage.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= ST_ARB;
            ptr_r   <= IDW'(NUM - 1);
            m_valid <= 1'b0;
            m_data  <= {DSIZE{1'b0}};
            m_last  <= 1'b0;
            m_id    <= {IDW{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            if (xfer_s) begin
                ptr_r   <= gnt_s;
                m_valid <= 1'b1;
                m_data  <= gnt_data_s;
                m_last  <= gnt_last_s;
                m_id    <= gnt_s;
            end else if (load_s) begin
                // Downstream took the beat (or none was held); payload kept as-is.
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end
        end
    end

endmodule

// File: tb/tb_data_c_rr_merge.sv
module tb_data_c_rr_merge;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    // Main instance: NUM=4, PKT_LOCK=1
    logic [3:0]  s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_last, m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_id;

    // No-lock instance: NUM=4, PKT_LOCK=0
    logic [3:0]  nl_s_valid, nl_s_last, nl_s_ready;
    logic [31:0] nl_s_data;
    logic        nl_m_valid, nl_m_last, nl_m_ready;
    logic [7:0]  nl_m_data;
    logic [1:0]  nl_m_id;

    // Single-channel instance
    logic [0:0]  o_s_valid, o_s_last, o_s_ready;
    logic [7:0]  o_s_data;
    logic        o_m_valid, o_m_last, o_m_ready;
    logic [7:0]  o_m_data;
    logic [0:0]  o_m_id;

    int errors = 0;
    int checks = 0;

    data_c_rr_merge #(.DSIZE(8), .NUM(4), .PKT_LOCK(1)) dut (
        .clock(clock), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_id(m_id), .m_ready(m_ready));

    data_c_rr_merge #(.DSIZE(8), .NUM(4), .PKT_LOCK(0)) dut_nl (
        .clock(clock), .rst(rst), .s_valid(nl_s_valid), .s_data(nl_s_data), .s_last(nl_s_last),
        .s_ready(nl_s_ready), .m_valid(nl_m_valid), .m_data(nl_m_data), .m_last(nl_m_last),
        .m_id(nl_m_id), .m_ready(nl_m_ready));

    data_c_rr_merge #(.DSIZE(8), .NUM(1), .PKT_LOCK(1)) dut_one (
        .clock(clock), .rst(rst), .s_valid(o_s_valid), .s_data(o_s_data), .s_last(o_s_last),
        .s_ready(o_s_ready), .m_valid(o_m_valid), .m_data(o_m_data), .m_last(o_m_last),
        .m_id(o_m_id), .m_ready(o_m_ready));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        s_valid = 4'b0; s_last = 4'b0; s_data = 32'h0; m_ready = 1'b1;
        nl_s_valid = 4'b0; nl_s_last = 4'b0; nl_s_data = 32'h0; nl_m_ready = 1'b1;
        o_s_valid = 1'b0; o_s_last = 1'b0; o_s_data = 8'h0; o_m_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        s_valid = 4'b1111; s_last = 4'b1111; s_data = 32'hDEADBEEF;
        nl_s_valid = 4'b1111; o_s_valid = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_valid, m_data, m_last, m_id} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b d=%h l=%0b id=%0d, want all 0", m_valid, m_data, m_last, m_id);
        end
        checks++;
        if ({s_ready, nl_s_ready, o_s_ready} !== 9'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b %b %b, want 0", s_ready, nl_s_ready, o_s_ready);
        end
        checks++;
        if ({nl_m_valid, o_m_valid, o_m_id} !== 3'b000) begin
            errors++;
            $display("FAIL reset_others: got nl_v=%0b o_v=%0b o_id=%0d, want 0", nl_m_valid, o_m_valid, o_m_id);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        s_valid = 4'b1111; s_last = 4'b1111; s_data = 32'h44332211; m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_id !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%0b id=%0d, want v=1 id=%0d", k, m_valid, m_id, k % 4);
            end
        end
        idle_inputs();
    endtask

    task automatic test_packet_lock();
        logic [1:0] exp_id [5];
        exp_id = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        m_ready = 1'b1;
        s_data = 32'h30201000;
        s_valid = 4'b0010; s_last = 4'b0010;
        tick();
        checks++;
        if (m_id !== exp_id[0]) begin
            errors++; $display("FAIL lock_id[0]: got %0d, want %0d", m_id, exp_id[0]);
        end
        for (int b = 1; b <= 3; b++) begin
            s_valid = 4'b0101;
            s_last  = (b == 3) ? 4'b0101 : 4'b0001;
            s_data  = {8'h30, 8'h20 + 8'(b), 8'h10, 8'h00};
            #1;
            checks++;
            if (s_ready !== 4'b0100) begin
                errors++; $display("FAIL lock_ready[%0d]: got %b, want 0100", b, s_ready);
            end
            tick();
            checks++;
            if (m_id !== exp_id[b] || m_data !== 8'h20 + 8'(b) || m_last !== (b == 3)) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got id=%0d d=%h l=%0b, want id=%0d d=%h l=%0b",
                         b, m_id, m_data, m_last, exp_id[b], 8'h20 + 8'(b), (b == 3));
            end
        end
        s_valid = 4'b0001;
        tick();
        checks++;
        if (m_id !== exp_id[4] || m_valid !== 1'b1) begin
            errors++; $display("FAIL lock_after: got v=%0b id=%0d, want v=1 id=0", m_valid, m_id);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        s_valid = 4'b0001; s_last = 4'b1111; s_data = 32'h000000A5; m_ready = 1'b0;
        tick();
        s_valid = 4'b0010; s_data = 32'h00003C00;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'hA5 || s_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall[%0d]: got v=%0b d=%h rdy=%b, want v=1 d=a5 rdy=0000", k, m_valid, m_data, s_ready);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (s_ready !== 4'b0010) begin
            errors++; $display("FAIL stall_release_ready: got %b, want 0010", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h3C || m_id !== 2'd1) begin
            errors++; $display("FAIL stall_next: got v=%0b d=%h id=%0d, want v=1 d=3c id=1", m_valid, m_data, m_id);
        end
        idle_inputs();
    endtask

    task automatic test_no_lock();
        do_reset();
        nl_s_valid = 4'b1010; nl_s_last = 4'b0000; nl_s_data = 32'hBB00AA00; nl_m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (nl_m_valid !== 1'b1 || nl_m_id !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
                errors++;
                $display("FAIL nolock[%0d]: got v=%0b id=%0d, want v=1 id=%0d", k, nl_m_valid, nl_m_id, (k % 2 == 0) ? 1 : 3);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        s_valid = 4'b1000; s_last = 4'b0000; s_data = 32'h77000000; m_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (m_id !== 2'd3 || m_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_beat2: got v=%0b id=%0d, want v=1 id=3", m_valid, m_id);
        end
        rst = 1'b1;
        s_valid = 4'b1111;
        tick();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
            errors++; $display("FAIL rstmid_reset: got v=%0b rdy=%b, want v=0 rdy=0000", m_valid, s_ready);
        end
        rst = 1'b0;
        s_valid = 4'b1010; s_last = 4'b1111; s_data = 32'h77006600;
        #1;
        checks++;
        if (s_ready !== 4'b0010) begin
            errors++; $display("FAIL rstmid_grant: got %b, want 0010", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_id !== 2'd1 || m_data !== 8'h66) begin
            errors++; $display("FAIL rstmid_next: got v=%0b id=%0d d=%h, want v=1 id=1 d=66", m_valid, m_id, m_data);
        end
        idle_inputs();
    endtask

    task automatic test_single_channel();
        int sent = 0;
        int recv = 0;
        logic acc;
        do_reset();
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            o_m_ready = (cyc % 2 == 0);
            o_s_valid = (sent < 10);
            o_s_data  = 8'h10 + 8'(sent);
            o_s_last  = (sent == 9);
            #1;
            acc = o_s_valid[0] && o_s_ready[0];
            if (o_m_valid && o_m_ready) begin
                checks++;
                if (o_m_data !== 8'h10 + 8'(recv) || o_m_id !== 1'b0 || o_m_last !== (recv == 9)) begin
                    errors++;
                    $display("FAIL one_beat[%0d]: got d=%h id=%0d l=%0b, want d=%h id=0 l=%0b",
                             recv, o_m_data, o_m_id, o_m_last, 8'h10 + 8'(recv), (recv == 9));
                end
                recv++;
            end
            @(posedge clock);
            if (acc) sent++;
            #1;
        end
        checks++;
        if (recv != 10) begin
            errors++; $display("FAIL one_count: got %0d beats, want 10", recv);
        end
        idle_inputs();
    endtask

    // Reference: "next requester after the last winner, in cyclic order".
    function automatic int ref_pick(input logic [3:0] v, input int last, output bit found);
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (v[(last + i) % 4]) begin
                found = 1'b1;
                return (last + i) % 4;
            end
        end
        return last;
    endfunction

    task automatic test_random();
        int  last_ch = 3;
        bit  in_pkt  = 1'b0;
        bit  out_full = 1'b0;
        logic [7:0] out_data = 8'h0;
        bit  out_last = 1'b0;
        int  out_id = 0;
        bit  found, space, take;
        int  who;
        logic [3:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            s_valid = 4'($urandom);
            s_last  = 4'($urandom) & 4'($urandom);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            space = !out_full || m_ready;
            if (in_pkt) begin
                who = last_ch; found = 1'b1;
            end else begin
                who = ref_pick(s_valid, last_ch, found);
            end
            exp_rdy = (found && space) ? (4'b0001 << who) : 4'b0000;
            take = found && space && s_valid[who];
            checks++;
            if (s_ready !== exp_rdy || m_valid !== out_full) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got rdy=%b v=%0b, want rdy=%b v=%0b", cyc, s_ready, m_valid, exp_rdy, out_full);
            end
            if (out_full) begin
                checks++;
                if (m_data !== out_data || m_last !== out_last || m_id !== 2'(out_id)) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got d=%h l=%0b id=%0d, want d=%h l=%0b id=%0d",
                             cyc, m_data, m_last, m_id, out_data, out_last, out_id);
                end
            end
            @(posedge clock);
            if (take) begin
                out_full = 1'b1;
                out_data = s_data[who*8 +: 8];
                out_last = s_last[who];
                out_id   = who;
                last_ch  = who;
                in_pkt   = !s_last[who];
            end else if (space) begin
                out_full = 1'b0;
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_stall();
        test_no_lock();
        test_reset_mid_packet();
        test_single_channel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_c_rr_merge.md
DATA_C_RR_MERGE -- requirements
Module: data_c_rr_merge

Interface
REQ-001 Parameter DSIZE, default 8: payload width per channel.
REQ-002 Parameter NUM, default 4: number of input channels, legal range 1..16.
REQ-003 Parameter PKT_LOCK, default 1: 1 holds the grant until s_last; 0 re-arbitrates every beat.
REQ-004 Parameter IDW, default $clog2(NUM) with minimum 1: width of m_id.
REQ-005 Port clock, input, 1: single clock; synchronous reset, active-high.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port s_valid, input, NUM: per-channel valid.
REQ-008 Port s_data, input, NUM*DSIZE: channel k occupies bits [k*DSIZE +: DSIZE].
REQ-009 Port s_last, input, NUM: per-channel end-of-packet.
REQ-010 Port s_ready, output, NUM: per-channel ready.
REQ-011 Port m_valid, output, 1: merged valid.
REQ-012 Port m_data, output, DSIZE: merged payload.
REQ-013 Port m_last, output, 1: merged end-of-packet.
REQ-014 Port m_id, output, IDW: source channel of the current beat.
REQ-015 Port m_ready, input, 1: downstream ready.

Function
REQ-016 Handshake: a transfer occurs when valid and ready are both high in the same cycle, on both sides.
REQ-017 Output is a single register stage. A beat accepted on cycle t appears on m_* at t+1.
REQ-018 Define load = !m_valid || m_ready. At most one bit of s_ready is high: s_ready[g] = load for the granted channel g; all other bits are 0.
REQ-019 While m_valid=1 and m_ready=0, m_data, m_last and m_id hold stable.
REQ-020 Throughput is one beat per cycle with no bubble while m_ready=1 and any channel is valid.
REQ-021 The state machine has two states: ARB and LOCK.
REQ-022 ARB state: g is the first channel with s_valid=1, searching cyclically from ptr+1 modulo NUM. ptr is the last granted channel.
REQ-023 ARB to LOCK: when PKT_LOCK=1 and a transfer occurs with s_last[g]=0.
REQ-024 LOCK state: g is fixed to ptr regardless of other channels' valid. LOCK returns to ARB on a transfer of ptr with s_last=1.
REQ-025 Each transfer sets ptr to g. The search wraps from NUM-1 to 0.
REQ-026 When PKT_LOCK=0, the block never enters LOCK.
REQ-027 In ARB with no valid channel, s_ready is all 0. The output drains normally and ptr is unchanged.
REQ-028 When NUM=1, m_id is constant 0 and s_ready[0] = load.
REQ-029 A grant decision in ARB depends only on the current cycle's s_valid and ptr. A channel dropping valid before a transfer does not consume its turn.

Reset
REQ-030 While rst=1: m_valid=0, m_data=0, m_last=0, m_id=0, state=ARB, ptr=NUM-1 (so channel 0 has first priority), and s_ready all 0.
REQ-031 Reset mid-packet abandons the lock. Any partially merged packet is not completed.

Structure
REQ-032 The state enum {ARB, LOCK} lives in the shared package data_c_pkg, together with the function that derives IDW.
REQ-033 The cyclic priority picker is the sub-module rr_pick (inputs: req[NUM], ptr; outputs: gnt index, any). It is purely combinational.
REQ-034 The top level holds the FSM, ptr and the output register.

Verification
REQ-035 Reset, then s_valid=4'b1111, all s_last=1, m_ready=1 -> m_id sequence 0,1,2,3,0 on consecutive cycles, with no gaps.
REQ-036 PKT_LOCK=1; channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> m_id=2,2,2 then 0.
REQ-037 m_ready=0 for 5 cycles with m_valid=1 and m_data=8'hA5 -> m_data stays 8'hA5 and s_ready=0 for all 5 cycles; transfer completes when m_ready returns to 1.
REQ-038 PKT_LOCK=0; channels 1 and 3 are valid with s_last=0 -> beats alternate m_id=1,3,1,3.
REQ-039 Assert rst for 1 cycle after beat 2 of a 4-beat packet on channel 3 -> m_valid=0 the next cycle, state=ARB, and the next grant goes to the lowest valid channel starting from 0.
REQ-040 NUM=1 build: stream 10 beats while m_ready toggles 1,0 -> all 10 beats arrive in order with m_id=0.
